// File: rtl/deselect_not_8_pkg.sv
// Shared constants for the select-not / deselect-not pair: lane width,
// channel select encodings and the per-channel counter width.
package deselect_not_8_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Undo the inversion applied by the select-not stage.
  function automatic logic [DATA_W-1:0] restore_byte(input logic [DATA_W-1:0] q);
    return ~q;
  endfunction

endpackage

// File: rtl/deselect_not_8_hold_slot.sv
// One-entry holding slot for a single output channel: data register, full
// flag, load/drain handshake and a wrapping count of loaded bytes.
module hold_slot
  import deselect_not_8_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             free_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drain;

  // Reset masks the handshake so nothing is consumed or offered while held.
  assign drain   = full_q & ready_i & ~rst;
  assign valid_o = full_q & ~rst;
  assign free_o  = ~rst & (~full_q | drain);
  assign data_o  = data_q;
  assign count_o = count_q;

  always_comb begin
    data_d  = data_q;
    full_d  = full_q;
    count_d = count_q;
    if (load_i) begin
      data_d  = load_data_i;
      full_d  = 1'b1;
      count_d = count_q + 1'b1;
    end else if (drain) begin
      full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      full_q  <= 1'b0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      full_q  <= full_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/deselect_not_8.sv
// Deselect-not stage: routes an inverted tagged byte to channel A or B,
// restores it and holds it in that channel's slot until consumed.
module deselect_not_8
  import deselect_not_8_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q_in,
  input  logic             s_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_out,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_out,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  // Handshake: a transfer happens on any rising edge where valid and ready
  // are both high; ready never looks at valid, valid never waits for ready.

  logic             a_free, b_free;
  logic             load_a, load_b;
  logic             accept;
  logic [WIDTH-1:0] restored;

  assign restored = ~q_in;
  assign in_ready = (s_in == SEL_A) ? a_free : b_free;
  assign accept   = in_valid & in_ready;
  assign load_a   = accept & (s_in == SEL_A);
  assign load_b   = accept & (s_in == SEL_B);

  hold_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_a),
    .load_data_i (restored),
    .ready_i     (a_ready),
    .data_o      (a_out),
    .valid_o     (a_valid),
    .free_o      (a_free),
    .count_o     (a_count)
  );

  hold_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_b),
    .load_data_i (restored),
    .ready_i     (b_ready),
    .data_o      (b_out),
    .valid_o     (b_valid),
    .free_o      (b_free),
    .count_o     (b_count)
  );

endmodule
